// File: rtl/fp_classify_pipe.sv
// Two-stage elastic FCLASS pipeline: stage 1 extracts exponent/mantissa flags and the
// NaN-box check, stage 2 registers the 10-bit one-hot RISC-V class mask.
module fp_classify_pipe #(
   parameter int unsigned FLEN  = 64,
   parameter int unsigned XLEN  = 32,
   parameter int unsigned TAG_W = 4
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_fmt,
   input  logic [TAG_W-1:0] in_tag,
   input  logic [FLEN-1:0]  rs1,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [TAG_W-1:0] out_tag,
   output logic [XLEN-1:0]  out
);

   logic f_sign, f_exp_ones, f_exp_zero, f_man_zero, f_quiet, f_box_fail;

   generate
      if (FLEN == 64) begin : g_dbl
         always_comb begin
            if (in_fmt) begin
               f_sign     = rs1[63];
               f_exp_ones = &rs1[62:52];
               f_exp_zero = ~|rs1[62:52];
               f_man_zero = ~|rs1[51:0];
               f_quiet    = rs1[51];
               f_box_fail = 1'b0;
            end else begin
               f_sign     = rs1[31];
               f_exp_ones = &rs1[30:23];
               f_exp_zero = ~|rs1[30:23];
               f_man_zero = ~|rs1[22:0];
               f_quiet    = rs1[22];
               f_box_fail = (rs1[63:32] != 32'hFFFF_FFFF);
            end
         end
      end else begin : g_sgl
         // Double format is unsupported here; in_fmt is ignored.
         logic unused_fmt;
         assign unused_fmt = in_fmt;
         always_comb begin
            f_sign     = rs1[31];
            f_exp_ones = &rs1[30:23];
            f_exp_zero = ~|rs1[30:23];
            f_man_zero = ~|rs1[22:0];
            f_quiet    = rs1[22];
            f_box_fail = 1'b0;
         end
      end
   endgenerate

   logic             s1_valid, s1_sign, s1_exp_ones, s1_exp_zero, s1_man_zero;
   logic             s1_quiet, s1_box_fail;
   logic [TAG_W-1:0] s1_tag;
   logic             s2_valid;
   logic [9:0]       s2_mask;
   logic [TAG_W-1:0] s2_tag;
   logic             s1_advance;
   logic [9:0]       cls;

   assign s1_advance = !s2_valid || out_ready;
   assign in_ready   = !s1_valid || s1_advance;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         s1_valid    <= 1'b0;
         s1_sign     <= 1'b0;
         s1_exp_ones <= 1'b0;
         s1_exp_zero <= 1'b0;
         s1_man_zero <= 1'b0;
         s1_quiet    <= 1'b0;
         s1_box_fail <= 1'b0;
         s1_tag      <= '0;
      end else begin
         if (flush) begin
            s1_valid <= 1'b0;
         end else if (in_ready) begin
            s1_valid <= in_valid;
         end
         if (in_valid && in_ready) begin
            s1_sign     <= f_sign;
            s1_exp_ones <= f_exp_ones;
            s1_exp_zero <= f_exp_zero;
            s1_man_zero <= f_man_zero;
            s1_quiet    <= f_quiet;
            s1_box_fail <= f_box_fail;
            s1_tag      <= in_tag;
         end
      end
   end

   always_comb begin
      cls = '0;
      if (s1_box_fail) begin
         cls[9] = 1'b1;
      end else if (s1_exp_ones && !s1_man_zero) begin
         if (s1_quiet) cls[9] = 1'b1;
         else          cls[8] = 1'b1;
      end else if (s1_exp_ones) begin
         if (s1_sign) cls[0] = 1'b1;
         else         cls[7] = 1'b1;
      end else if (s1_exp_zero && s1_man_zero) begin
         if (s1_sign) cls[3] = 1'b1;
         else         cls[4] = 1'b1;
      end else if (s1_exp_zero) begin
         if (s1_sign) cls[2] = 1'b1;
         else         cls[5] = 1'b1;
      end else begin
         if (s1_sign) cls[1] = 1'b1;
         else         cls[6] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         s2_valid <= 1'b0;
         s2_mask  <= '0;
         s2_tag   <= '0;
      end else begin
         if (flush) begin
            s2_valid <= 1'b0;
         end else if (s1_advance) begin
            s2_valid <= s1_valid;
         end
         if (s1_valid && s1_advance) begin
            s2_mask <= cls;
            s2_tag  <= s1_tag;
         end
      end
   end

   assign out_valid = s2_valid;
   assign out_tag   = s2_tag;

   always_comb begin
      out      = '0;
      out[9:0] = s2_mask;
   end

endmodule

// File: tb/tb_fp_classify_pipe.sv
// Directed-vector bench for fp_classify_pipe: per-vector latency checks, streaming with a
// scoreboard, backpressure, flush and asynchronous reset sequences.
module tb_fp_classify_pipe;
   localparam int FLEN  = 64;
   localparam int XLEN  = 32;
   localparam int TAG_W = 4;
   localparam int NV    = 17;

   logic             clk = 1'b0;
   logic             resetn, flush, in_valid, in_ready, in_fmt, out_valid, out_ready;
   logic [TAG_W-1:0] in_tag, out_tag;
   logic [FLEN-1:0]  rs1;
   logic [XLEN-1:0]  out;

   always #5 clk = ~clk;

   fp_classify_pipe #(.FLEN(FLEN), .XLEN(XLEN), .TAG_W(TAG_W)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_fmt    (in_fmt),
      .in_tag    (in_tag),
      .rs1       (rs1),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_tag   (out_tag),
      .out       (out)
   );

   typedef struct {
      logic        fmt;
      logic [63:0] rs1;
      logic [9:0]  mask;
   } vec_t;

   typedef struct {
      logic [TAG_W-1:0] tag;
      logic [9:0]       mask;
   } exp_t;

   vec_t             vecs[NV];
   exp_t             sb[$];
   exp_t             mon_e;
   logic [9:0]       cur_exp;
   int               n_checks = 0;
   int               n_fail   = 0;
   int               n_out    = 0;
   int               n0, k;
   logic [XLEN-1:0]  held_out;
   logic [TAG_W-1:0] held_tag;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int idx, input logic [TAG_W-1:0] tag);
      in_valid = 1'b1;
      in_fmt   = vecs[idx].fmt;
      rs1      = vecs[idx].rs1;
      in_tag   = tag;
      cur_exp  = vecs[idx].mask;
   endtask

   // One isolated operation: accepted, invisible after one edge, visible after two.
   task automatic single(input int idx, input logic [TAG_W-1:0] tag);
      drive(idx, tag);
      @(negedge clk);
      check("accept_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      check("lat1_out_valid", out_valid, 0);
      tick();
      @(negedge clk);
      check("lat2_out_valid", out_valid, 1);
      check($sformatf("vec%0d_out", idx), out, vecs[idx].mask);
      check($sformatf("vec%0d_tag", idx), out_tag, tag);
      tick();
   endtask

   // Scoreboard: expected results are queued on input transfer and compared on output transfer.
   always @(negedge clk) begin
      if (!resetn || flush) begin
         sb.delete();
      end else begin
         if (out_valid && out_ready) begin
            n_out++;
            if (sb.size() == 0) begin
               check("unexpected_output", out_valid, 0);
            end else begin
               mon_e = sb.pop_front();
               check("stream_out", out, mon_e.mask);
               check("stream_tag", out_tag, mon_e.tag);
            end
         end
         if (in_valid && in_ready) sb.push_back('{in_tag, cur_exp});
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish, got no end, expected end");
      $fatal(1);
   end

   initial begin
      resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_fmt = 1'b0;
      rs1 = '0; in_tag = '0; out_ready = 1'b1; cur_exp = '0;

      vecs[0]  = '{1'b1, 64'hFFF0_0000_0000_0000, 10'h001};
      vecs[1]  = '{1'b1, 64'h8000_0000_0000_0000, 10'h008};
      vecs[2]  = '{1'b1, 64'h0000_0000_0000_0001, 10'h020};
      vecs[3]  = '{1'b1, 64'h3FF0_0000_0000_0000, 10'h040};
      vecs[4]  = '{1'b1, 64'h7FF8_0000_0000_0000, 10'h200};
      vecs[5]  = '{1'b1, 64'h7FF0_0000_0000_0001, 10'h100};
      vecs[6]  = '{1'b0, 64'hFFFF_FFFF_7F80_0000, 10'h080};
      vecs[7]  = '{1'b0, 64'hFFFF_FFFF_8000_0000, 10'h008};
      vecs[8]  = '{1'b0, 64'h0000_0000_3F80_0000, 10'h200};
      vecs[9]  = '{1'b1, 64'h0000_0000_0000_0000, 10'h010};
      vecs[10] = '{1'b1, 64'h800F_FFFF_FFFF_FFFF, 10'h004};
      vecs[11] = '{1'b1, 64'hC000_0000_0000_0000, 10'h002};
      vecs[12] = '{1'b0, 64'hFFFF_FFFF_7FA0_0000, 10'h100};
      vecs[13] = '{1'b0, 64'hFFFF_FFFF_FFC0_0000, 10'h200};
      vecs[14] = '{1'b0, 64'hFFFF_FFFF_0000_0001, 10'h020};
      vecs[15] = '{1'b0, 64'hFFFF_FFFF_3F80_0000, 10'h040};
      vecs[16] = '{1'b0, 64'hFFFF_FFFE_3F80_0000, 10'h200};

      repeat (2) @(posedge clk);
      #1;
      check("reset_out_valid", out_valid, 0);
      check("reset_out", out, 0);
      check("reset_out_tag", out_tag, 0);
      resetn = 1'b1;
      @(negedge clk);
      check("reset_in_ready", in_ready, 1);
      tick();

      for (int i = 0; i < NV; i++) single(i, TAG_W'(i));

      // Back-to-back stream of 8 with tags 0..7.
      n0 = n_out;
      for (int i = 0; i < 11; i++) begin
         if (i < 8) drive(i, TAG_W'(i));
         else in_valid = 1'b0;
         @(negedge clk);
         if (i < 8) check("b2b_in_ready", in_ready, 1);
         check("b2b_out_valid", out_valid, (i >= 2 && i < 10));
         tick();
      end
      check("b2b_count", n_out - n0, 8);

      // Backpressure: output stalled for 5 cycles with the input streaming.
      out_ready = 1'b0;
      k = 0;
      n0 = n_out;
      for (int cyc = 0; cyc < 5; cyc++) begin
         drive(k, TAG_W'(8 + k));
         @(negedge clk);
         check("bp_in_ready", in_ready, (cyc < 2));
         check("bp_out_valid", out_valid, (cyc >= 2));
         if (cyc == 2) begin
            held_out = out;
            held_tag = out_tag;
            check("bp_first_out", out, vecs[0].mask);
            check("bp_first_tag", out_tag, 8);
         end else if (cyc > 2) begin
            check("bp_hold_out", out, held_out);
            check("bp_hold_tag", out_tag, held_tag);
         end
         if (in_ready) k++;
         tick();
      end
      out_ready = 1'b1;
      for (int c = 0; c < 20 && k < 6; c++) begin
         drive(k, TAG_W'(8 + k));
         @(negedge clk);
         if (in_ready) k++;
         tick();
      end
      in_valid = 1'b0;
      repeat (4) tick();
      check("bp_count", n_out - n0, 6);
      check("bp_sb_empty", sb.size(), 0);

      // Flush with two ops in flight and a third presented alongside the flush.
      out_ready = 1'b0;
      drive(0, 4'd1);
      @(negedge clk);
      tick();
      drive(1, 4'd2);
      @(negedge clk);
      tick();
      drive(2, 4'd3);
      out_ready = 1'b1;
      flush = 1'b1;
      @(negedge clk);
      check("fl_in_ready", in_ready, 1);
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      n0 = n_out;
      @(negedge clk);
      check("fl_out_valid", out_valid, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         @(negedge clk);
         check("fl_quiet", out_valid, 0);
      end
      tick();
      check("fl_none_emerged", n_out - n0, 0);
      single(3, 4'd5);

      // Flush while the output is stalled.
      drive(4, 4'd6);
      @(negedge clk);
      tick();
      in_valid = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      tick();
      flush = 1'b1;
      @(negedge clk);
      check("fl2_pre_valid", out_valid, 1);
      tick();
      flush = 1'b0;
      @(negedge clk);
      check("fl2_post_valid", out_valid, 0);
      out_ready = 1'b1;
      tick();

      // Asynchronous reset mid-stream.
      drive(5, 4'd9);
      tick();
      drive(6, 4'd10);
      tick();
      drive(7, 4'd11);
      #2;
      resetn = 1'b0;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out", out, 0);
      check("rst_out_tag", out_tag, 0);
      in_valid = 1'b0;
      @(negedge clk);
      tick();
      resetn = 1'b1;
      n0 = n_out;
      @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      repeat (3) tick();
      check("rst_no_output", n_out - n0, 0);
      single(8, 4'd12);

      check("final_sb_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fp_classify_pipe.md
Name: fp_classify_pipe

Overview:
- Parametrised, pipelined FCLASS unit for the FP execution path.
- Classifies single-precision operands, and double-precision operands when FLEN=64, into the 10-bit one-hot RISC-V class mask.
- Checks NaN-boxing of single-precision values held in 64-bit registers.
- Two-stage elastic pipeline with valid/ready handshake, tag passthrough and flush; sits between FP register-file read and the integer writeback arbiter.

Parameters:
- FLEN, 64, FP register width; legal values 32 or 64.
- XLEN, 32, integer result width; must be 10 or more.
- TAG_W, 4, width of the opaque tag carried alongside each operation.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- flush  in  1  synchronous kill of all in-flight operations
- in_valid  in  1  operand valid
- in_ready  out  1  unit can accept an operand this cycle
- in_fmt  in  1  format: 0 = single (8-bit exponent, 23-bit mantissa), 1 = double (11-bit exponent, 52-bit mantissa)
- in_tag  in  TAG_W  destination/ROB tag
- rs1  in  FLEN  operand
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_tag  out  TAG_W  tag of the result
- out  out  XLEN  class mask; bits [XLEN-1:10] are always 0

Behaviour:
- Reset (resetn low, async): both stage valid flags = 0, out_valid = 0, out = 0, out_tag = 0. in_ready = 1 once resetn is high.
- Handshake:
  - Transfer occurs when valid && ready on the same clock edge.
  - in_ready = !s1_valid || s1_advance, where s1_advance = !s2_valid || out_ready.
  - Holding rule: out_valid, out and out_tag remain stable while out_valid && !out_ready.
  - Full throughput: one operation per cycle when out_ready is held at 1.
  - Latency: 2 cycles from input transfer to out_valid.
- Stage 1 (field extract), registers:
  - sign, exponent-all-ones, exponent-all-zero, mantissa-zero, mantissa MSB (quiet bit), box_fail, tag.
  - fmt=1 when FLEN=32: treated as fmt=0, i.e. the upper format is unsupported and ignored.
  - fmt=0 when FLEN=64: box_fail = (rs1[63:32] != 32'hFFFFFFFF), and fields are taken from rs1[31:0].
  - fmt=1: fields are taken from rs1[63:0]; box_fail = 0.
- Stage 2 (classify), registers a one-hot mask; exactly one bit is set per valid result. Rules, first match wins:
  - box_fail -> bit 9 (canonical qNaN).
  - exponent all ones, mantissa nonzero, quiet bit 1 -> bit 9 (qNaN).
  - exponent all ones, mantissa nonzero, quiet bit 0 -> bit 8 (sNaN).
  - exponent all ones, mantissa zero -> bit 0 if sign else bit 7.
  - exponent zero, mantissa zero -> bit 3 if sign else bit 4.
  - exponent zero, mantissa nonzero -> bit 2 if sign else bit 5.
  - otherwise (normal) -> bit 1 if sign else bit 6.
- Flush:
  - Clears both stage valid flags on the next edge.
  - An input presented with flush in the same cycle is discarded.
  - out_valid falls the cycle after flush even if out_ready = 0.
  - Data registers need not clear.
- Simultaneous events:
  - Stage 2 may load a new result on the same edge that out_ready retires the old one.
  - flush has priority over every transfer.
- Reset mid-operation: all in-flight operations are lost; no output handshake completes after reset.
- Combinational paths: no combinational path from rs1 to out. The only combinational path to in_ready is from out_ready.

Test Plan:
- FLEN=64, fmt=1 operands 0xFFF0000000000000, 0x8000000000000000, 0x0000000000000001, 0x3FF0000000000000, 0x7FF8000000000000, 0x7FF0000000000001 -> out = 0x001, 0x008, 0x020, 0x040, 0x200, 0x100, each 2 cycles after accept.
- fmt=0: rs1 = 0xFFFFFFFF7F800000 -> 0x080; rs1 = 0xFFFFFFFF80000000 -> 0x008; rs1 = 0x000000003F800000 (bad box) -> 0x200.
- Back-to-back: 8 operands on consecutive cycles with out_ready = 1 -> 8 results on consecutive cycles, in order, tags 0..7 preserved.
- Backpressure: out_ready = 0 for 5 cycles with a stream at the input -> in_ready drops after 2 accepts; output held stable; no loss or duplication after release.
- Flush with 2 ops in flight plus one presented -> out_valid = 0 the next cycle; none of the 3 ops emerge; a new op afterwards emerges with latency 2.
- resetn asserted asynchronously mid-stream -> out_valid, out and out_tag go to 0 immediately; after release the first op returns a correct result.
